simon_sequencer: RTL and testbench

Game-flow controller for the Simon memory game. It grows a random 2-bit sequence, plays it back by driving the shared LED/tone path, then checks the player's button presses against it. It reports game over or win. It sits between the button interpreter and the num/pressed multiplexer that feeds the LED decoder, frequency mapper and speaker.

---
 rtl/simon_pkg.sv | 24 ++
 rtl/simon_sequencer_if.sv | 26 ++
 rtl/simon_lfsr.sv | 24 ++
 rtl/simon_sequencer.sv | 169 ++++++++++++++++
 tb/tb_simon_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - state encoding, button type and LFSR taps shared by the Simon sequencer
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_PLAY_ON,
        ST_PLAY_OFF,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_OVER,
        ST_WIN
    } simon_state_t;

    typedef logic [1:0] btn_t;

    // x^8 + x^6 + x^5 + x^4 + 1, bits 7/5/4/3 of a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// rtl/simon_sequencer_if.sv - player/playback signal bundle between the Simon sequencer and its neighbours
interface simon_sequencer_if;
    import simon_pkg::*;

    logic       tick;
    logic       start;
    btn_t       player_num;
    logic       player_pressed;
    logic       simon_turn;
    btn_t       simon_num;
    logic       simon_pressed;
    logic [3:0] level;
    logic       game_over;
    logic       win;

    modport master (
        output tick, start, player_num, player_pressed,
        input  simon_turn, simon_num, simon_pressed, level, game_over, win
    );

    modport slave (
        input  tick, start, player_num, player_pressed,
        output simon_turn, simon_num, simon_pressed, level, game_over, win
    );

endinterface

// File: rtl/simon_lfsr.sv
// rtl/simon_lfsr.sv - free-running 8-bit Fibonacci LFSR; exposes the two bits used for new sequence entries
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] bits_o
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign bits_o = lfsr_q[1:0];

endmodule

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game flow: grow, play back and check a random sequence.
// Optional SIMON_TIMEOUT_EN: a press not arriving within TIMEOUT_TICKS ticks ends the game.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN       = 10,
    parameter int unsigned ON_TICKS      = 2,
    parameter int unsigned OFF_TICKS     = 1,
    parameter logic [7:0]  SEED          = 8'hA5,
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic clk,
    input  logic reset,
    simon_sequencer_if.slave bus
);

    localparam int unsigned SPAN    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned CNT_MAX = (SPAN > TIMEOUT_TICKS) ? SPAN : TIMEOUT_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    simon_state_t     state_q, state_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pp_q;
    logic             mem_we;
    btn_t             mem_q [16];
    btn_t             lfsr_bits;
    btn_t             play_num;
    logic             last;
    logic             rise;

    logic             turn_q;
    logic             pressed_q;
    btn_t             num_q;
    logic [3:0]       level_q;
    logic             over_q;
    logic             win_q;

    simon_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .bits_o (lfsr_bits)
    );

    assign last = (idx_q == len_q - 4'd1);
    assign rise = bus.player_pressed & ~pp_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (bus.start) begin
                    state_d = ST_ADD;
                    len_d   = 4'd0;
                end
            end
            ST_ADD: begin
                mem_we  = 1'b1;
                len_d   = len_q + 4'd1;
                idx_d   = 4'd0;
                cnt_d   = '0;
                state_d = ST_PLAY_ON;
            end
            ST_PLAY_ON: begin
                if (bus.tick) begin
                    if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY_OFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY_OFF: begin
                if (bus.tick) begin
                    if (cnt_q == CNT_W'(OFF_TICKS - 1)) begin
                        cnt_d = '0;
                        if (last) begin
                            idx_d   = 4'd0;
                            state_d = ST_WAIT_PRESS;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = ST_PLAY_ON;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT_PRESS: begin
                // an edge in the same cycle as the final timeout tick still counts as a press
                if (rise) begin
                    state_d = (bus.player_num == mem_q[idx_q]) ? ST_WAIT_RELEASE : ST_OVER;
                end
`ifdef SIMON_TIMEOUT_EN
                else if (bus.tick) begin
                    if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = ST_OVER;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            ST_WAIT_RELEASE: begin
                if (!bus.player_pressed) begin
                    if (last) begin
                        state_d = (len_q == 4'(MAX_LEN)) ? ST_WIN : ST_ADD;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = '0;
                        state_d = ST_WAIT_PRESS;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // the first note of a round can be the entry being written this very cycle
    assign play_num = (mem_we && (idx_d == len_q)) ? lfsr_bits : mem_q[idx_d];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[len_q] <= lfsr_bits;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= 4'd0;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            pp_q      <= 1'b0;
            turn_q    <= 1'b0;
            pressed_q <= 1'b0;
            num_q     <= '0;
            level_q   <= 4'd0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pp_q      <= bus.player_pressed;
            turn_q    <= (state_d == ST_PLAY_ON) || (state_d == ST_PLAY_OFF);
            pressed_q <= (state_d == ST_PLAY_ON);
            num_q     <= (state_d == ST_PLAY_ON) ? play_num : 2'd0;
            level_q   <= len_d;
            over_q    <= (state_d == ST_OVER);
            win_q     <= (state_d == ST_WIN);
        end
    end

    assign bus.simon_turn    = turn_q;
    assign bus.simon_pressed = pressed_q;
    assign bus.simon_num     = num_q;
    assign bus.level         = level_q;
    assign bus.game_over     = over_q;
    assign bus.win           = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - randomized games against a game-level Simon model, plus pinned literal cases
module tb_simon_sequencer;

    localparam int MAXL = 2;
    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int TO   = 8;

    localparam int M_IDLE = 0, M_ADD = 1, M_NOTE = 2, M_GAP = 3;
    localparam int M_WAIT = 4, M_HOLD = 5, M_LOST = 6, M_WON = 7;

    logic clk = 1'b0;
    logic reset;
    int   n_chk;
    int   n_pass;

    simon_sequencer_if bus ();

    simon_sequencer #(
        .MAX_LEN       (MAXL),
        .ON_TICKS      (ON),
        .OFF_TICKS     (OFF),
        .SEED          (8'hA5),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         m_mode;
    logic [1:0] m_seq [$];
    int         m_pos;
    int         m_ticks;
    int         m_wait;
    logic       m_prev;
    logic [7:0] m_lf;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        $display("FAIL %s: got no progress, expected target state within budget (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_seq.delete();
        m_pos   = 0;
        m_ticks = 0;
        m_wait  = 0;
        m_prev  = 1'b0;
        m_lf    = 8'hA5;
    endtask

    // one clock of game rules, using the inputs present before the edge
    task automatic model_step(input logic t, input logic s, input logic [1:0] n, input logic p);
        logic rise;
        rise = p && !m_prev;
        case (m_mode)
            M_IDLE, M_LOST, M_WON: if (s) begin m_seq.delete(); m_mode = M_ADD; end
            M_ADD: begin
                m_seq.push_back(m_lf[1:0]);
                m_pos = 0; m_ticks = 0; m_mode = M_NOTE;
            end
            M_NOTE: if (t) begin
                m_ticks++;
                if (m_ticks == ON) begin m_ticks = 0; m_mode = M_GAP; end
            end
            M_GAP: if (t) begin
                m_ticks++;
                if (m_ticks == OFF) begin
                    m_ticks = 0;
                    if (m_pos == m_seq.size() - 1) begin m_pos = 0; m_wait = 0; m_mode = M_WAIT; end
                    else begin m_pos++; m_mode = M_NOTE; end
                end
            end
            M_WAIT: begin
                if (rise) m_mode = (n == m_seq[m_pos]) ? M_HOLD : M_LOST;
`ifdef SIMON_TIMEOUT_EN
                else if (t) begin
                    m_wait++;
                    if (m_wait == TO) m_mode = M_LOST;
                end
`endif
            end
            M_HOLD: if (!p) begin
                if (m_pos == m_seq.size() - 1) m_mode = (m_seq.size() == MAXL) ? M_WON : M_ADD;
                else begin m_pos++; m_wait = 0; m_mode = M_WAIT; end
            end
            default: m_mode = M_IDLE;
        endcase
        m_prev = p;
        m_lf   = {m_lf[6:0], m_lf[7] ^ m_lf[5] ^ m_lf[4] ^ m_lf[3]};
    endtask

    task automatic cyc(input logic t, input logic s, input logic [1:0] n, input logic p);
        bus.tick           = t;
        bus.start          = s;
        bus.player_num     = n;
        bus.player_pressed = p;
        @(posedge clk);
        if (!reset) model_step(t, s, n, p);
        @(negedge clk);
    endtask

    task automatic advance(input int target, input logic [1:0] n, input logic p);
        int g;
        g = 0;
        while (m_mode != target && g < 2000) begin
            cyc($urandom_range(0, 1) == 1, 1'b0, n, p);
            g++;
        end
        if (m_mode != target) bound_fail("advance");
    endtask

    task automatic play_random(input int wrong_pct);
        logic       t, s, p;
        logic [1:0] n;
        int         guard;
        guard = 0;
        p = bus.player_pressed;
        n = bus.player_num;
        if (m_mode == M_IDLE || m_mode == M_LOST || m_mode == M_WON)
            cyc($urandom_range(0, 1) == 1, 1'b1, n, p);
        while (m_mode != M_LOST && m_mode != M_WON && guard < 3000) begin
            guard++;
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 15) == 0);
            case (m_mode)
                M_WAIT: begin
                    if (p) begin
                        if ($urandom_range(0, 2) == 0) p = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        p = 1'b1;
                        n = m_seq[m_pos];
                        if ($urandom_range(0, 99) < wrong_pct) n = n ^ 2'($urandom_range(1, 3));
                    end
                end
                M_HOLD: if ($urandom_range(0, 2) == 0) p = 1'b0;
                default: if ($urandom_range(0, 7) == 0) begin
                    p = ~p;
                    n = 2'($urandom_range(0, 3));
                end
            endcase
            cyc(t, s, n, p);
        end
        if (guard >= 3000) bound_fail("game");
    endtask

    always @(negedge clk) begin
        chk("simon_turn", int'(bus.simon_turn), int'(m_mode == M_NOTE || m_mode == M_GAP));
        chk("simon_pressed", int'(bus.simon_pressed), int'(m_mode == M_NOTE));
        if (m_mode == M_NOTE) chk("simon_num", int'(bus.simon_num), int'(m_seq[m_pos]));
        if (m_mode == M_IDLE) chk("idle_num", int'(bus.simon_num), 0);
        chk("level", int'(bus.level), m_seq.size());
        chk("game_over", int'(bus.game_over), int'(m_mode == M_LOST));
        chk("win", int'(bus.win), int'(m_mode == M_WON));
    end

    initial begin
        logic [1:0] wrong;
        n_chk  = 0;
        n_pass = 0;
        bus.tick = 1'b0; bus.start = 1'b0; bus.player_num = 2'd0; bus.player_pressed = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        repeat (3) cyc(1'b0, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;

        // start on the first edge after reset: entry comes from LFSR value 8'h4A
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("first_note", int'(bus.simon_num), 2);
        chk("first_level", int'(bus.level), 1);
        chk("first_turn", int'(bus.simon_turn), 1);

        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_turn", int'(bus.simon_turn), 0);
        chk("rst_pressed", int'(bus.simon_pressed), 0);
        chk("rst_num", int'(bus.simon_num), 0);
        chk("rst_level", int'(bus.level), 0);
        @(negedge clk);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        chk("restart_note", int'(bus.simon_num), 2);
        chk("restart_level", int'(bus.level), 1);

        // round 1, then hold a wrong button through the round-2 playback
        advance(M_WAIT, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, m_seq[0], 1'b1);
        cyc(1'b1, 1'b0, m_seq[0], 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        wrong = m_seq[0] ^ 2'd1;
        advance(M_WAIT, wrong, 1'b1);
        chk("round2_level", int'(bus.level), 2);
        repeat (6) cyc(1'b1, 1'b0, wrong, 1'b1);
        chk("held_no_over", int'(bus.game_over), 0);
        cyc(1'b0, 1'b0, wrong, 1'b0);
        cyc(1'b0, 1'b0, m_seq[0], 1'b1);
        cyc(1'b0, 1'b0, m_seq[0], 1'b0);
        cyc(1'b0, 1'b0, m_seq[1], 1'b1);
        cyc(1'b0, 1'b0, m_seq[1], 1'b0);
        chk("win_set", int'(bus.win), 1);
        chk("win_level", int'(bus.level), 2);
        cyc(1'b1, 1'b1, 2'd0, 1'b0);
        chk("win_cleared", int'(bus.win), 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        chk("new_game_level", int'(bus.level), 1);

        advance(M_WAIT, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, m_seq[0] ^ 2'd3, 1'b1);
        chk("wrong_over", int'(bus.game_over), 1);
        chk("wrong_level", int'(bus.level), 1);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);

        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        advance(M_WAIT, 2'd0, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        repeat (TO - 1) begin
            cyc(1'b1, 1'b0, 2'd0, 1'b0);
            cyc(1'b0, 1'b0, 2'd0, 1'b0);
        end
        chk("timeout_before", int'(bus.game_over), 0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("timeout_at", int'(bus.game_over), 1);
`else
        repeat (100) begin
            cyc(1'b1, 1'b0, 2'd0, 1'b0);
            cyc(1'b0, 1'b0, 2'd0, 1'b0);
        end
        chk("no_timeout", int'(bus.game_over), 0);
`endif

        for (int g = 0; g < 40; g++) play_random($urandom_range(0, 30));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
